// File: rtl/pocket_hit_arbiter_pkg.sv
// Shared types and defaults for the pocket hit arbiter.
package pocket_hit_arbiter_pkg;

  // Default number of ball requesters.
  localparam int unsigned NumBallsDefault = 4;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StHoldoff = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pocket_hit_arbiter_rr_pick.sv
// Round-robin winner search: first set bit of pending at or after ptr, wrapping.
module pocket_hit_arbiter_rr_pick #(
  parameter int unsigned NumBalls = 4,
  parameter int unsigned IdW      = $clog2(NumBalls)
) (
  input  logic [NumBalls-1:0] pending_i,
  input  logic [IdW-1:0]      ptr_i,
  output logic [IdW-1:0]      winner_o,
  output logic                any_valid_o
);

  // Scan NumBalls positions starting at ptr; the first pending one wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    winner_o    = '0;
    any_valid_o = 1'b0;
    for (int unsigned k = 0; k < NumBalls; k++) begin
      idx = (32'(ptr_i) + k) % NumBalls;
      if (!any_valid_o && pending_i[idx]) begin
        winner_o    = IdW'(idx);
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pocket_hit_arbiter.sv
// Pocket hit arbiter: collects per-ball hole hits, presents one at a time to the
// score/removal unit, and allows at most one sink per video frame.
module pocket_hit_arbiter
  import pocket_hit_arbiter_pkg::*;
#(
  parameter int unsigned NUM_BALLS   = NumBallsDefault,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic                         newRack,
  input  logic [NUM_BALLS-1:0]         ballHitReq,
  input  logic                         hitAck,
  output logic                         hitValid,
  output logic [$clog2(NUM_BALLS)-1:0] hitBallId,
  output logic [NUM_BALLS-1:0]         sunkMask,
  output logic                         allSunk,
  output logic                         timeoutErr
);

  localparam int unsigned IdW  = $clog2(NUM_BALLS);
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  arb_state_e           state_q;
  logic [NUM_BALLS-1:0] pending_q;
  logic [NUM_BALLS-1:0] sunk_q;
  logic [IdW-1:0]       ptr_q;
  logic [IdW-1:0]       hit_id_q;
  logic                 hit_valid_q;
  logic                 timeout_err_q;
  logic [CntW-1:0]      wait_cnt_q;

  logic [NUM_BALLS-1:0] new_req;
  logic [NUM_BALLS-1:0] id_onehot;
  logic [IdW-1:0]       next_ptr;
  logic [IdW-1:0]       winner;
  logic                 any_valid;
  logic                 wait_expired;

  // Sunk balls can no longer request.
  assign new_req      = ballHitReq & ~sunk_q;
  assign id_onehot    = {{(NUM_BALLS - 1){1'b0}}, 1'b1} << hit_id_q;
  assign next_ptr     = (hit_id_q == IdW'(NUM_BALLS - 1)) ? '0 : hit_id_q + 1'b1;
  assign wait_expired = (wait_cnt_q == CntW'(ACK_TIMEOUT));

  pocket_hit_arbiter_rr_pick #(
    .NumBalls (NUM_BALLS),
    .IdW      (IdW)
  ) rr_pick (
    .pending_i   (pending_q),
    .ptr_i       (ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // FSM with registered outputs; reset beats newRack, newRack beats everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      sunk_q        <= '0;
      ptr_q         <= '0;
      hit_id_q      <= '0;
      hit_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else if (newRack) begin
      // Same-cycle requests are dropped along with the old pending set.
      state_q       <= StIdle;
      pending_q     <= '0;
      sunk_q        <= '0;
      ptr_q         <= '0;
      hit_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      pending_q     <= pending_q | new_req;
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            state_q     <= StGrant;
            hit_id_q    <= winner;
            hit_valid_q <= 1'b1;
            wait_cnt_q  <= '0;
          end
        end
        StGrant: begin
          // Ack wins over a coinciding timeout.
          if (hitAck) begin
            sunk_q      <= sunk_q | id_onehot;
            pending_q   <= (pending_q | new_req) & ~id_onehot;
            ptr_q       <= next_ptr;
            hit_valid_q <= 1'b0;
            state_q     <= StHoldoff;
          end else if (wait_expired) begin
            // Ball stays pending so it is offered again in a later frame.
            timeout_err_q <= 1'b1;
            ptr_q         <= next_ptr;
            hit_valid_q   <= 1'b0;
            state_q       <= StHoldoff;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StHoldoff: begin
          if (startOfFrame) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hitValid   = hit_valid_q;
  assign hitBallId  = hit_id_q;
  assign sunkMask   = sunk_q;
  assign allSunk    = &sunk_q;
  assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_pocket_hit_arbiter.sv
// Directed bench for pocket_hit_arbiter (4 balls, short ack timeout of 4).
module tb_pocket_hit_arbiter;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic       newRack;
  logic [3:0] ballHitReq;
  logic       hitAck;
  logic       hitValid;
  logic [1:0] hitBallId;
  logic [3:0] sunkMask;
  logic       allSunk;
  logic       timeoutErr;

  int checks = 0;
  int errors = 0;

  pocket_hit_arbiter #(
    .NUM_BALLS   (4),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .newRack      (newRack),
    .ballHitReq   (ballHitReq),
    .hitAck       (hitAck),
    .hitValid     (hitValid),
    .hitBallId    (hitBallId),
    .sunkMask     (sunkMask),
    .allSunk      (allSunk),
    .timeoutErr   (timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From IDLE with a pending ball: grant it, check the id, then acknowledge.
  task automatic grant_ack(input int exp_id, input string tag);
    tick();
    check({tag, "_valid"}, 32'(hitValid), 32'd1);
    check({tag, "_id"}, 32'(hitBallId), 32'(exp_id));
    hitAck = 1'b1;
    tick();
    hitAck = 1'b0;
    check({tag, "_drop"}, 32'(hitValid), 32'd0);
  endtask

  task automatic next_frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic do_new_rack();
    newRack = 1'b1;
    tick();
    newRack = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    newRack      = 1'b0;
    ballHitReq   = 4'b0000;
    hitAck       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(hitValid), 32'd0);
    check("rst_id", 32'(hitBallId), 32'd0);
    check("rst_sunk", 32'(sunkMask), 32'd0);
    check("rst_allsunk", 32'(allSunk), 32'd0);
    check("rst_timeout", 32'(timeoutErr), 32'd0);

    // Single hit: request at edge k, presented after edge k+1.
    ballHitReq = 4'b0010;
    tick();
    ballHitReq = 4'b0000;
    check("single_not_yet", 32'(hitValid), 32'd0);
    grant_ack(1, "single");
    check("single_sunk", 32'(sunkMask), 32'b0010);
    // New request in HOLDOFF accumulates but waits for the frame.
    ballHitReq = 4'b0001;
    tick();
    ballHitReq = 4'b0000;
    tick();
    tick();
    check("holdoff_wait", 32'(hitValid), 32'd0);
    next_frame();
    check("idle_after_sof", 32'(hitValid), 32'd0);
    grant_ack(0, "after_frame");
    check("after_frame_sunk", 32'(sunkMask), 32'b0011);
    do_new_rack();
    check("rack1_sunk", 32'(sunkMask), 32'd0);

    // Round-robin from ptr 0 over pending 1011.
    ballHitReq = 4'b1011;
    tick();
    ballHitReq = 4'b0000;
    grant_ack(0, "rr0");
    next_frame();
    grant_ack(1, "rr1");
    next_frame();
    grant_ack(3, "rr3");
    check("rr_sunk", 32'(sunkMask), 32'b1011);
    check("rr_allsunk", 32'(allSunk), 32'd0);
    do_new_rack();

    // Timeout on ball 2: valid through 5 GRANT cycles, then error pulse.
    ballHitReq = 4'b0100;
    tick();
    ballHitReq = 4'b0000;
    tick();
    check("to_valid_c1", 32'(hitValid), 32'd1);
    check("to_id", 32'(hitBallId), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_valid_hold", 32'(hitValid), 32'd1);
      check("to_no_err", 32'(timeoutErr), 32'd0);
    end
    tick();
    check("to_err_pulse", 32'(timeoutErr), 32'd1);
    check("to_drop", 32'(hitValid), 32'd0);
    check("to_not_sunk", 32'(sunkMask), 32'd0);
    tick();
    check("to_err_one_cycle", 32'(timeoutErr), 32'd0);
    check("to_holdoff", 32'(hitValid), 32'd0);
    next_frame();
    tick();
    check("to_regrant", 32'(hitValid), 32'd1);
    check("to_regrant_id", 32'(hitBallId), 32'd2);

    // Ack lands in the cycle the counter reaches the timeout.
    for (int i = 0; i < 4; i++) tick();
    check("coll_still_valid", 32'(hitValid), 32'd1);
    hitAck = 1'b1;
    tick();
    hitAck = 1'b0;
    check("coll_sunk", 32'(sunkMask), 32'b0100);
    check("coll_no_err", 32'(timeoutErr), 32'd0);
    check("coll_drop", 32'(hitValid), 32'd0);
    do_new_rack();

    // newRack during GRANT with three balls sunk.
    ballHitReq = 4'b0111;
    tick();
    ballHitReq = 4'b0000;
    grant_ack(0, "nr0");
    next_frame();
    grant_ack(1, "nr1");
    next_frame();
    grant_ack(2, "nr2");
    check("nr_sunk", 32'(sunkMask), 32'b0111);
    next_frame();
    ballHitReq = 4'b1000;
    tick();
    ballHitReq = 4'b0000;
    tick();
    check("nr_grant3", 32'(hitValid), 32'd1);
    check("nr_grant3_id", 32'(hitBallId), 32'd3);
    newRack    = 1'b1;
    ballHitReq = 4'b0001;
    tick();
    newRack    = 1'b0;
    ballHitReq = 4'b0000;
    check("nr_drop", 32'(hitValid), 32'd0);
    check("nr_clear", 32'(sunkMask), 32'd0);
    tick();
    tick();
    check("nr_req_discarded", 32'(hitValid), 32'd0);

    // Sink all four balls, then further requests are ignored.
    ballHitReq = 4'b1111;
    tick();
    ballHitReq = 4'b0000;
    grant_ack(0, "all0");
    next_frame();
    grant_ack(1, "all1");
    next_frame();
    grant_ack(2, "all2");
    next_frame();
    grant_ack(3, "all3");
    check("all_sunk_mask", 32'(sunkMask), 32'b1111);
    check("all_sunk_flag", 32'(allSunk), 32'd1);
    next_frame();
    ballHitReq = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("all_no_grant", 32'(hitValid), 32'd0);
    end
    ballHitReq = 4'b0000;
    do_new_rack();
    check("all_rack_clear", 32'(allSunk), 32'd0);

    // Reset during GRANT drops the hit without sinking it.
    ballHitReq = 4'b0001;
    tick();
    ballHitReq = 4'b0000;
    tick();
    check("rg_valid", 32'(hitValid), 32'd1);
    hitAck = 1'b1;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    hitAck = 1'b0;
    check("rg_drop", 32'(hitValid), 32'd0);
    check("rg_not_sunk", 32'(sunkMask), 32'd0);
    tick();
    tick();
    check("rg_pending_cleared", 32'(hitValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pocket_hit_arbiter.md
POCKET_HIT_ARBITER -- requirements
Module: pocket_hit_arbiter

Interface
REQ-001 Parameter NUM_BALLS, default 4: number of ball requesters; supported range 2..8.
REQ-002 Parameter ACK_TIMEOUT, default 255: maximum number of clk cycles spent waiting for hitAck.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 startOfFrame  input  1  one-cycle pulse at each frame start (30Hz).
REQ-006 newRack  input  1  one-cycle pulse that restarts the game state.
REQ-007 ballHitReq  input  NUM_BALLS  level per ball; high while that ball overlaps a black hole.
REQ-008 hitAck  input  1  score/removal unit accepts the presented hit.
REQ-009 hitValid  output  1  a hit is being presented.
REQ-010 hitBallId  output  clog2(NUM_BALLS)  index of the presented ball; stable while hitValid is high.
REQ-011 sunkMask  output  NUM_BALLS  registered; bit i high means ball i has been sunk.
REQ-012 allSunk  output  1  high when every bit of sunkMask is set.
REQ-013 timeoutErr  output  1  one-cycle pulse when a presentation is abandoned.

Function
REQ-014 A pending bit per ball SHALL be set at the edge where ballHitReq[i]=1 and sunkMask[i]=0.
REQ-015 Requests from sunk balls SHALL be ignored.
REQ-016 The FSM SHALL have three states: IDLE, GRANT and HOLDOFF.
REQ-017 In IDLE with any pending bit set, the block SHALL take the next edge to GRANT and latch the winner into hitBallId; hitValid is high from that edge on.
REQ-018 Latency: with a request sampled at edge k and the FSM in IDLE, hitValid SHALL be high after edge k+1.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer ptr and increments modulo NUM_BALLS; the first pending ball wins.
REQ-020 In GRANT, hitValid and hitBallId SHALL hold until hitAck or timeout.
REQ-021 If new requests arrive during GRANT, they SHALL only set pending bits; the presented hit is not changed.
REQ-022 hitAck in GRANT: set sunkMask[id], clear pending[id], set ptr=(id+1) mod NUM_BALLS, drop hitValid, go to HOLDOFF.
REQ-023 hitAck outside GRANT SHALL be ignored.
REQ-024 A wait counter SHALL clear on entry to GRANT and increment each GRANT cycle without hitAck.
REQ-025 When the wait counter reaches ACK_TIMEOUT: pulse timeoutErr, keep pending[id] set, set ptr=(id+1) mod NUM_BALLS, drop hitValid, go to HOLDOFF.
REQ-026 If hitAck and timeout occur in the same cycle, hitAck SHALL win and timeoutErr stays low.
REQ-027 HOLDOFF SHALL go to IDLE on startOfFrame, giving at most one sink per frame for animation.
REQ-028 startOfFrame in IDLE or GRANT SHALL have no effect.
REQ-029 newRack SHALL have highest priority in every state, taking effect at the next edge: clear pending, sunkMask and ptr; set state to IDLE; drop hitValid.
REQ-030 If a ballHitReq is high in the same cycle as newRack, it SHALL be discarded.
REQ-031 allSunk SHALL be combinational from sunkMask (AND of all bits).
REQ-032 In HOLDOFF, pending bits SHALL continue to accumulate.

Reset
REQ-033 While reset is high, at each edge the block SHALL load: state=IDLE, pending=0, sunkMask=0, ptr=0, wait counter=0, hitValid=0, hitBallId=0, timeoutErr=0.
REQ-034 Reset asserted during GRANT SHALL drop hitValid at the next edge; no sunk bit is set.
REQ-035 Reset SHALL take priority over newRack.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (IDLE, GRANT, HOLDOFF) and the NUM_BALLS default constant.
REQ-037 The round-robin winner search SHALL be one combinational sub-module, rr_pick: inputs pending and ptr; outputs winner index and anyValid.

Verification
REQ-038 Single hit: ballHitReq=0010 at edge k -> hitValid=1 with hitBallId=1 after edge k+1; hitAck -> sunkMask=0010; no new grant until startOfFrame.
REQ-039 Round-robin: pending=1011, ptr=0 -> grants in order 0,1,3, one per frame; sunkMask=1011 at the end.
REQ-040 Timeout: ACK_TIMEOUT=4, ball 2 granted, no hitAck -> timeoutErr pulses in the 5th GRANT cycle; pending[2] remains set; ball 2 is re-granted after the next startOfFrame.
REQ-041 Ack/timeout collision: hitAck arrives in the same cycle the counter reaches ACK_TIMEOUT -> sunkMask bit set, timeoutErr=0.
REQ-042 newRack during GRANT with sunkMask=0111 -> next edge: hitValid=0, sunkMask=0, state IDLE; a ballHitReq held high in that same cycle is not granted.
REQ-043 Sink all: sink all 4 balls -> allSunk=1; further ballHitReq=1111 produces no hitValid.
